// File: rtl/pixel_stream_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : pixel_stream_feeder_if
// Description : Pixel stream handshake bundle (valid/data/last/ready).
// Revision    : 1.0 - initial release
// ============================================================================
interface pixel_stream_feeder_if;
  logic       valid;
  logic [7:0] data;
  logic       last;
  logic       ready;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface
`default_nettype wire

// File: rtl/pixel_stream_feeder.sv
`default_nettype none
// ============================================================================
// Module      : pixel_stream_feeder
// Description : Credit-paced frame-memory to pixel-stream source with a
//               2-entry skid buffer and zero-filled trailing pad lines.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_stream_feeder #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int INIT_LINES = 4,
  parameter int PAD_LINES  = 1,
  parameter int ADDR_W     = 18
) (
  input  wire logic             i_clk,
  input  wire logic             i_rst,
  input  wire logic             i_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_mem_rd_en,
  output logic [ADDR_W-1:0]     o_mem_addr,
  input  wire logic [7:0]       i_mem_data,
  input  wire logic             i_intr,
  pixel_stream_feeder_if.master pix
);

  localparam int c_TOTAL_LINES = IMG_HEIGHT + PAD_LINES;
  localparam int c_LINE_W      = $clog2(c_TOTAL_LINES + 1);
  localparam int c_COL_W       = $clog2(IMG_WIDTH);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SEND  = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [15:0]         credits_q, credits_d;
  logic [c_LINE_W-1:0] line_q;
  logic [c_COL_W-1:0]  col_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                done_q;

  // Stage 1: issue made last cycle, memory data arriving this cycle
  logic                s1_valid_q;
  logic                s1_pad_q;
  logic                s1_last_q;

  // Skid buffer: output register plus one spare entry
  logic                out_valid_q;
  logic [7:0]          out_data_q;
  logic                out_last_q;
  logic                sp_valid_q;
  logic [7:0]          sp_data_q;
  logic                sp_last_q;

  logic                w_pop;
  logic [1:0]          w_occ;
  logic                w_room;
  logic                w_line_start;
  logic                w_col_wrap;
  logic                w_is_image;
  logic                w_issue;
  logic                w_final_issue;
  logic                w_final_xfer;
  logic [7:0]          w_push_data;

  assign w_pop         = out_valid_q & pix.ready;
  assign w_occ         = 2'(out_valid_q) + 2'(sp_valid_q) + 2'(s1_valid_q) - 2'(w_pop);
  assign w_room        = (w_occ < 2'd2);
  assign w_line_start  = (col_q == '0);
  assign w_col_wrap    = (col_q == c_COL_W'(IMG_WIDTH - 1));
  assign w_is_image    = (line_q < c_LINE_W'(IMG_HEIGHT));
  assign w_issue       = (state_q == c_SEND) && w_room &&
                         (!w_line_start || (credits_q != 16'd0));
  assign w_final_issue = w_issue && w_col_wrap && (line_q == c_LINE_W'(c_TOTAL_LINES - 1));
  assign w_final_xfer  = (state_q == c_DRAIN) && w_pop && !sp_valid_q && !s1_valid_q;
  assign w_push_data   = s1_pad_q ? 8'd0 : i_mem_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= c_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:  if (i_start)       state_d = c_SEND;
      c_SEND:  if (w_final_issue) state_d = c_DRAIN;
      c_DRAIN: if (w_final_xfer)  state_d = c_IDLE;
      default:                    state_d = c_IDLE;
    endcase
  end

  always_comb begin
    o_busy      = (state_q != c_IDLE);
    o_mem_rd_en = w_issue && w_is_image;
  end

  // A same-cycle interrupt and line start cancel out
  always_comb begin
    credits_d = credits_q;
    if (state_q == c_IDLE) begin
      if (i_start) credits_d = 16'(INIT_LINES);
    end else begin
      case ({i_intr, w_issue && w_line_start})
        2'b10:   if (credits_q != 16'hFFFF) credits_d = credits_q + 16'd1;
        2'b01:   credits_d = credits_q - 16'd1;
        default: credits_d = credits_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      credits_q   <= 16'd0;
      line_q      <= '0;
      col_q       <= '0;
      addr_q      <= '0;
      done_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_pad_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
      out_last_q  <= 1'b0;
      sp_valid_q  <= 1'b0;
      sp_data_q   <= 8'd0;
      sp_last_q   <= 1'b0;
    end else begin
      credits_q  <= credits_d;
      done_q     <= w_final_xfer;
      s1_valid_q <= w_issue;
      s1_pad_q   <= !w_is_image;
      s1_last_q  <= w_col_wrap;

      if ((state_q == c_IDLE) && i_start) begin
        line_q <= '0;
        col_q  <= '0;
        addr_q <= '0;
      end else if (w_issue) begin
        if (w_is_image) addr_q <= addr_q + ADDR_W'(1);
        if (w_col_wrap) begin
          col_q  <= '0;
          line_q <= line_q + c_LINE_W'(1);
        end else begin
          col_q  <= col_q + c_COL_W'(1);
        end
      end

      // Output slot refills from the spare first to keep order
      if (!out_valid_q || w_pop) begin
        if (sp_valid_q) begin
          out_valid_q <= 1'b1;
          out_data_q  <= sp_data_q;
          out_last_q  <= sp_last_q;
          sp_valid_q  <= s1_valid_q;
          sp_data_q   <= w_push_data;
          sp_last_q   <= s1_last_q;
        end else begin
          out_valid_q <= s1_valid_q;
          if (s1_valid_q) begin
            out_data_q <= w_push_data;
            out_last_q <= s1_last_q;
          end
        end
      end else if (s1_valid_q) begin
        sp_valid_q <= 1'b1;
        sp_data_q  <= w_push_data;
        sp_last_q  <= s1_last_q;
      end
    end
  end

  assign o_done     = done_q;
  assign o_mem_addr = addr_q;
  assign pix.valid  = out_valid_q;
  assign pix.data   = out_data_q;
  assign pix.last   = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_stream_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_stream_feeder
// Description : Scoreboard bench for pixel_stream_feeder (4x3 image, 1 pad line).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_stream_feeder;

  localparam int W = 4;
  localparam int H = 3;
  localparam int NPIX = W * (H + 1);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       intr = 1'b0;
  logic       busy, done, rd_en;
  logic [3:0] addr;
  logic [7:0] mem_data = 8'hEE;

  pixel_stream_feeder_if pif();

  pixel_stream_feeder #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .INIT_LINES(2), .PAD_LINES(1), .ADDR_W(4)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .o_busy(busy), .o_done(done),
    .o_mem_rd_en(rd_en), .o_mem_addr(addr), .i_mem_data(mem_data),
    .i_intr(intr), .pix(pif)
  );

  always #5 clk = ~clk;

  // Frame memory: mem[k] = k+16, junk when not read
  always @(posedge clk) mem_data <= rd_en ? (8'(addr) + 8'd16) : 8'hEE;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int xfer_cnt = 0;
  int reads_cnt = 0;
  int done_cnt = 0;
  int last_xfer_cyc = -10;
  int exp_addr = 0;
  logic [8:0] sb[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Output monitor: scoreboard pops, stability, read address and done checks
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst) begin
      if (prev_stall) begin
        chk("hold_valid", pif.valid, 1);
        chk("hold_data", pif.data, prev_data);
        chk("hold_last", pif.last, prev_last);
      end
      if (rd_en) begin
        reads_cnt++;
        chk("rd_addr", addr, exp_addr);
        chk("rd_in_image", int'(addr < 4'd12), 1);
        exp_addr++;
      end
      if (pif.valid && pif.ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_xfer", pif.data, -1);
        end else begin
          e = sb.pop_front();
          chk("xfer_data", pif.data, e[8:1]);
          chk("xfer_last", pif.last, e[0]);
        end
        xfer_cnt++;
        last_xfer_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        chk("done_timing", cyc, last_xfer_cyc + 1);
        chk("busy_at_done", busy, 0);
      end
    end
    prev_stall = pif.valid && !pif.ready && !rst;
    prev_data  = pif.data;
    prev_last  = pif.last;
  end

  typedef struct {
    bit start;
    bit intr;
    int n_pix;
    int base;
    bit pad;
    int n_reads;
    bit busy_after;
    int done_after;
  } phase_t;

  task automatic push_frame(input int n, input int base, input bit pad);
    for (int k = 0; k < n; k++)
      sb.push_back({(pad ? 8'd0 : 8'(base + k)), ((k % W) == W - 1)});
  endtask

  task automatic wait_drain(input string name, input bit toggle);
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      if (toggle) pif.ready = ~pif.ready;
      n++;
    end
    chk(name, sb.size(), 0);
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_rd_en"}, rd_en, 0);
    chk({name, "_addr"}, addr, 0);
    chk({name, "_valid"}, pif.valid, 0);
    chk({name, "_data"}, pif.data, 0);
    chk({name, "_last"}, pif.last, 0);
  endtask

  initial begin
    phase_t tbl[3];
    int n;
    bit f1, f2;

    tbl[0] = '{start: 1, intr: 0, n_pix: 8, base: 16, pad: 0, n_reads: 8, busy_after: 1, done_after: 0};
    tbl[1] = '{start: 0, intr: 1, n_pix: 4, base: 24, pad: 0, n_reads: 4, busy_after: 1, done_after: 0};
    tbl[2] = '{start: 0, intr: 1, n_pix: 4, base: 0,  pad: 1, n_reads: 0, busy_after: 0, done_after: 1};

    // Reset held with start asserted
    pif.ready = 1'b1;
    rst = 1'b1;
    start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_outputs_zero("reset");
    end
    @(posedge clk);
    #1 rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_rd_en", rd_en, 0);

    // Table-driven: initial credits, then one line per interrupt, then pad
    exp_addr = 0;
    done_cnt = 0;
    for (int p = 0; p < 3; p++) begin
      @(posedge clk);
      #1;
      reads_cnt = 0;
      push_frame(tbl[p].n_pix, tbl[p].base, tbl[p].pad);
      start = tbl[p].start;
      intr  = tbl[p].intr;
      @(posedge clk);
      #1 start = 1'b0;
      intr = 1'b0;
      wait_drain("phase_drain", 1'b0);
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("phase_reads", reads_cnt, tbl[p].n_reads);
      chk("phase_busy", busy, tbl[p].busy_after);
      chk("phase_done", done_cnt, tbl[p].done_after);
    end

    // Alternating backpressure with interrupt held high
    @(posedge clk);
    #1;
    exp_addr = 0;
    done_cnt = 0;
    intr = 1'b1;
    push_frame(NPIX - W, 16, 1'b0);
    push_frame(W, 0, 1'b1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_drain("bp_drain", 1'b1);
    pif.ready = 1'b1;
    intr = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("bp_done", done_cnt, 1);
    chk("bp_busy", busy, 0);

    // Interrupt coincident with line-2 start, repeated start mid-frame
    @(posedge clk);
    #1;
    exp_addr = 0;
    done_cnt = 0;
    f1 = 0;
    f2 = 0;
    push_frame(NPIX - W, 16, 1'b0);
    push_frame(W, 0, 1'b1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      intr = 1'b0;
      if (rd_en && addr == 4'd5 && !f1) begin
        intr = 1'b1;
        f1 = 1;
      end else if (rd_en && addr == 4'd8) begin
        intr = 1'b1;
        f2 = 1;
      end
      start = (n == 4);
      @(posedge clk);
      #1 intr = 1'b0;
      start = 1'b0;
      n++;
    end
    chk("sim_drain", sb.size(), 0);
    chk("sim_line2_seen", f2, 1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("sim_done", done_cnt, 1);
    chk("sim_busy", busy, 0);

    // Reset after second transfer of line 1, then clean restart
    @(posedge clk);
    #1;
    exp_addr = 0;
    done_cnt = 0;
    xfer_cnt = 0;
    push_frame(NPIX - W, 16, 1'b0);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (xfer_cnt < 6 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("pre_reset_xfers", xfer_cnt, 6);
    #1 rst = 1'b1;
    pif.ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_outputs_zero("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    pif.ready = 1'b1;
    sb.delete();
    exp_addr = 0;
    done_cnt = 0;
    intr = 1'b1;
    push_frame(NPIX - W, 16, 1'b0);
    push_frame(W, 0, 1'b1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_drain("restart_drain", 1'b0);
    intr = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("restart_done", done_cnt, 1);
    chk("restart_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d, want completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
